ritc_dac_readback: RTL and testbench

RITC DAC chain readback receiver: the listening end of the RITC DAC serial-load interface. It watches the DAC clock and latch strobes that the DAC loader drives, and samples both RITCs' DAC_DOUT lines. From these it rebuilds the 33 × 12-bit words previously held in each RITC's DAC chain and stores them in a readback buffer. It sits next to the dual-DAC block on the same user register bus, so software can check that the last load actually reached the chip.

---
 rtl/ritc_dac_readback_pkg.sv | 35 +++
 rtl/ritc_dac_readback_chan.sv | 60 ++++++
 rtl/ritc_dac_readback.sv | 174 +++++++++++++++++
 tb/tb_ritc_dac_readback.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ritc_dac_readback_pkg.sv
// Constants and types shared by the RITC DAC readback receiver and the dual-DAC loader.
package ritc_dac_readback_pkg;

    localparam int RB_NUM_DACS    = 33;
    localparam int RB_DAC_BITS    = 12;
    localparam int RB_CHAIN_BITS  = RB_NUM_DACS * RB_DAC_BITS;   // 396
    localparam int RB_SYNC_STAGES = 2;
    localparam int RB_IDX_W       = 6;                            // 64-entry buffer per RITC
    localparam int RB_CNT_W       = 9;                            // bit counter, saturates at 511

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } rb_state_t;

    // Control register bits
    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;

    // Status register bits
    localparam int STAT_ARMED     = 0;
    localparam int STAT_CAPTURING = 1;
    localparam int STAT_DONE      = 2;
    localparam int STAT_LEN_ERR   = 3;
    localparam int STAT_OVERFLOW  = 4;
    localparam int STAT_COUNT_LSB = 16;

    // Buffer window field offsets (read and pointer write share the layout)
    localparam int WIN_WORD_LSB = 0;
    localparam int WIN_IDX_LSB  = 12;
    localparam int WIN_RITC_BIT = 18;

endpackage

// File: rtl/ritc_dac_readback_chan.sv
// One RITC readback lane: MSB-first shift register, bit-in-word counter and word buffer.
module ritc_dac_readback_chan
    import ritc_dac_readback_pkg::*;
#(
    parameter int NUM_DACS = RB_NUM_DACS,
    parameter int DAC_BITS = RB_DAC_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_clear,
    input  logic                i_sample,
    input  logic                i_dout,
    input  logic                i_we,
    input  logic [RB_IDX_W-1:0] i_wr_idx,
    input  logic [RB_IDX_W-1:0] i_rd_idx,
    output logic [DAC_BITS-1:0] o_rd_word,
    output logic                o_word_ready
);

    localparam int                BIT_W    = $clog2(DAC_BITS);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DAC_BITS - 1);

    logic [DAC_BITS-1:0] r_sr;
    logic [BIT_W-1:0]    r_bit_idx;
    logic                r_word_ready;
    logic [DAC_BITS-1:0] r_ram [2**RB_IDX_W];

    // Shift in one DOUT bit per accepted sample; flag a complete word for one cycle.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
        if (rst_i || i_clear) begin
            r_sr         <= '0;
            r_bit_idx    <= '0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_sample) begin
                r_sr <= {r_sr[DAC_BITS-2:0], i_dout};
                if (r_bit_idx == LAST_BIT) begin
                    r_bit_idx    <= '0;
                    r_word_ready <= 1'b1;
                end else begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end
        end
    end

    // Store the completed word one cycle after its last bit; samples are >=2 cycles apart so r_sr is stable.
    always_ff @(posedge clk_i) begin
        // NOTE: the buffer has no reset so it maps to distributed RAM; software only trusts words from a completed capture.
        if (i_we) begin
            r_ram[i_wr_idx] <= r_sr;
        end
    end

    assign o_rd_word    = (i_rd_idx < RB_IDX_W'(NUM_DACS)) ? r_ram[i_rd_idx] : '0;
    assign o_word_ready = r_word_ready;

endmodule

// File: rtl/ritc_dac_readback.sv
// RITC DAC chain readback: rebuilds both RITC DAC chains from DOUT and exposes them on the user bus.
module ritc_dac_readback
    import ritc_dac_readback_pkg::*;
#(
    parameter int NUM_DACS    = RB_NUM_DACS,
    parameter int DAC_BITS    = RB_DAC_BITS,
    parameter int SYNC_STAGES = RB_SYNC_STAGES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  dac_clock_i,
    input  logic [1:0]  dac_latch_i,
    input  logic [1:0]  dac_dout_i,
    input  logic        user_sel_i,
    input  logic        user_wr_i,
    input  logic        user_rd_i,
    input  logic        user_addr_i,
    input  logic [31:0] user_dat_i,
    output logic [31:0] user_dat_o,
    output logic        capture_done_o
);

    localparam logic [RB_CNT_W-1:0] CHAIN_CNT = RB_CNT_W'(NUM_DACS * DAC_BITS);
    localparam logic [RB_IDX_W-1:0] WORDS_IDX = RB_IDX_W'(NUM_DACS);

    logic [SYNC_STAGES-1:0]      r_clk_dly, r_latch_dly;
    logic [SYNC_STAGES-1:0][1:0] r_dout_sync;
    logic                        r_clk_prev, r_latch_prev;
    rb_state_t                   r_state, w_state_next;
    logic [RB_CNT_W-1:0]         r_bit_count, w_count_next;
    logic [RB_IDX_W-1:0]         r_word_idx, r_ptr_idx;
    logic                        r_len_err, r_overflow, r_ptr_ritc;
    logic [31:0]                 r_dat_o, w_status, w_window;
    logic [DAC_BITS-1:0]         w_rd_word0, w_rd_word1;
    logic                        w_ready0, w_ready1;

    // Bit 1 of the clock/latch taps mirrors bit 0; the other inputs are simply not part of the map.
    logic w_unused;
    assign w_unused = ^{dac_clock_i[1], dac_latch_i[1], user_rd_i, user_dat_i[31:19], user_dat_i[11:2]};

    // Synchronise DOUT and delay the clock/latch taps by the same depth so all three stay aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_dly    <= '0;
            r_latch_dly  <= '0;
            r_dout_sync  <= '0;
            r_clk_prev   <= 1'b0;
            r_latch_prev <= 1'b0;
        end else begin
            r_clk_dly[0]   <= dac_clock_i[0];
            r_latch_dly[0] <= dac_latch_i[0];
            r_dout_sync[0] <= dac_dout_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_dly[i]   <= r_clk_dly[i-1];
                r_latch_dly[i] <= r_latch_dly[i-1];
                r_dout_sync[i] <= r_dout_sync[i-1];
            end
            r_clk_prev   <= r_clk_dly[SYNC_STAGES-1];
            r_latch_prev <= r_latch_dly[SYNC_STAGES-1];
        end
    end

    logic w_sample, w_latch, w_ctrl_wr, w_ptr_wr, w_arm, w_abort, w_arm_eff;
    logic w_active, w_count_event, w_in_range, w_accept, w_we;

    assign w_sample      = r_clk_dly[SYNC_STAGES-1] & ~r_clk_prev;
    assign w_latch       = r_latch_dly[SYNC_STAGES-1] & ~r_latch_prev;
    assign w_ctrl_wr     = user_sel_i & user_wr_i & user_addr_i;
    assign w_ptr_wr      = user_sel_i & user_wr_i & ~user_addr_i;
    assign w_arm         = w_ctrl_wr & user_dat_i[CTRL_ARM];
    assign w_abort       = w_ctrl_wr & user_dat_i[CTRL_ABORT];
    assign w_arm_eff     = w_arm & ~w_abort;
    assign w_active      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign w_count_event = w_sample & w_active;
    assign w_in_range    = r_bit_count < CHAIN_CNT;
    assign w_accept      = w_count_event & w_in_range & ~w_ctrl_wr;
    assign w_count_next  = (w_count_event && (r_bit_count != '1)) ? r_bit_count + 1'b1 : r_bit_count;
    assign w_we          = (w_ready0 | w_ready1) & (r_word_idx < WORDS_IDX);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: abort beats arm, arm beats everything else; a latch ends an active capture.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end else if (w_arm) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED:   if (w_latch) w_state_next = ST_DONE;
                            else if (w_sample) w_state_next = ST_CAPTURE;
                ST_CAPTURE: if (w_latch) w_state_next = ST_DONE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    // Bit counter and error flags; a sample coinciding with the latch is counted before the length check.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_arm_eff) begin
            r_bit_count <= '0;
            r_len_err   <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_active && !w_abort) begin
            r_bit_count <= w_count_next;
            if (w_count_event && !w_in_range) r_overflow <= 1'b1;
            if (w_latch) r_len_err <= (w_count_next != CHAIN_CNT);
        end
    end

    // Word index advances once per stored word and never wraps past the chain.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_arm_eff) begin
            r_word_idx <= '0;
        end else if (w_we) begin
            r_word_idx <= r_word_idx + 1'b1;
        end
    end

    ritc_dac_readback_chan #(.NUM_DACS(NUM_DACS), .DAC_BITS(DAC_BITS)) u_chan0 (
        .clk_i(clk_i), .rst_i(rst_i), .i_clear(w_arm_eff), .i_sample(w_accept),
        .i_dout(r_dout_sync[SYNC_STAGES-1][0]), .i_we(w_we), .i_wr_idx(r_word_idx),
        .i_rd_idx(r_ptr_idx), .o_rd_word(w_rd_word0), .o_word_ready(w_ready0)
    );

    ritc_dac_readback_chan #(.NUM_DACS(NUM_DACS), .DAC_BITS(DAC_BITS)) u_chan1 (
        .clk_i(clk_i), .rst_i(rst_i), .i_clear(w_arm_eff), .i_sample(w_accept),
        .i_dout(r_dout_sync[SYNC_STAGES-1][1]), .i_we(w_we), .i_wr_idx(r_word_idx),
        .i_rd_idx(r_ptr_idx), .o_rd_word(w_rd_word1), .o_word_ready(w_ready1)
    );

    // Assemble the status word and the buffer window word.
    always_comb begin
        w_status                                = '0;
        w_status[STAT_ARMED]                    = (r_state == ST_ARMED);
        w_status[STAT_CAPTURING]                = (r_state == ST_CAPTURE);
        w_status[STAT_DONE]                     = (r_state == ST_DONE);
        w_status[STAT_LEN_ERR]                  = r_len_err;
        w_status[STAT_OVERFLOW]                 = r_overflow;
        w_status[STAT_COUNT_LSB +: RB_CNT_W]    = r_bit_count;
        w_window                                = '0;
        w_window[WIN_WORD_LSB +: DAC_BITS]      = r_ptr_ritc ? w_rd_word1 : w_rd_word0;
        w_window[WIN_IDX_LSB +: RB_IDX_W]       = r_ptr_idx;
        w_window[WIN_RITC_BIT]                  = r_ptr_ritc;
    end

    // Read pointer and registered read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr_ritc <= 1'b0;
            r_ptr_idx  <= '0;
            r_dat_o    <= '0;
        end else begin
            if (w_ptr_wr) begin
                r_ptr_ritc <= user_dat_i[WIN_RITC_BIT];
                r_ptr_idx  <= user_dat_i[WIN_IDX_LSB +: RB_IDX_W];
            end
            r_dat_o <= user_addr_i ? w_status : w_window;
        end
    end

    assign user_dat_o     = r_dat_o;
    assign capture_done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_ritc_dac_readback.sv
// Directed bench for ritc_dac_readback: a loader model replays known chains into both DOUT lines.
module tb_ritc_dac_readback;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  dac_clock_i, dac_latch_i, dac_dout_i;
    logic        user_sel_i, user_wr_i, user_rd_i, user_addr_i;
    logic [31:0] user_dat_i;
    logic [31:0] user_dat_o;
    logic        capture_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    ritc_dac_readback dut (
        .clk_i(clk), .rst_i(rst_i),
        .dac_clock_i(dac_clock_i), .dac_latch_i(dac_latch_i), .dac_dout_i(dac_dout_i),
        .user_sel_i(user_sel_i), .user_wr_i(user_wr_i), .user_rd_i(user_rd_i),
        .user_addr_i(user_addr_i), .user_dat_i(user_dat_i), .user_dat_o(user_dat_o),
        .capture_done_o(capture_done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ctrl_write(input logic [31:0] val);
        user_sel_i = 1'b1; user_wr_i = 1'b1; user_addr_i = 1'b1; user_dat_i = val;
        tick();
        user_sel_i = 1'b0; user_wr_i = 1'b0; user_dat_i = '0;
    endtask

    task automatic read_status(output logic [31:0] val);
        user_sel_i = 1'b1; user_rd_i = 1'b1; user_addr_i = 1'b1;
        tick(); tick();
        val = user_dat_o;
        user_sel_i = 1'b0; user_rd_i = 1'b0;
    endtask

    task automatic read_word(input logic ritc, input logic [5:0] idx, output logic [31:0] val);
        user_sel_i = 1'b1; user_wr_i = 1'b1; user_addr_i = 1'b0;
        user_dat_i = {13'd0, ritc, idx, 12'd0};
        tick();
        user_wr_i = 1'b0; user_rd_i = 1'b1; user_dat_i = '0;
        tick(); tick(); tick();
        val = user_dat_o;
        user_sel_i = 1'b0; user_rd_i = 1'b0;
    endtask

    // Loader model: word i of RITC0 is base0+i, of RITC1 base1+i, shifted MSB first.
    task automatic shift_bits(input logic [11:0] base0, input logic [11:0] base1, input int nbits);
        logic [11:0] w0, w1;
        int          pos;
        for (int b = 0; b < nbits; b++) begin
            w0  = base0 + 12'(b / 12);
            w1  = base1 + 12'(b / 12);
            pos = 11 - (b % 12);
            dac_dout_i  = {w1[pos], w0[pos]};
            dac_clock_i = 2'b00;
            tick();
            dac_clock_i = 2'b11;
            tick();
        end
        dac_clock_i = 2'b00;
        tick();
    endtask

    task automatic pulse_latch();
        tick(); tick();
        dac_latch_i = 2'b11;
        tick();
        dac_latch_i = 2'b00;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rst_i = 1'b1;
        dac_clock_i = '0; dac_latch_i = '0; dac_dout_i = '0;
        user_sel_i = 1'b0; user_wr_i = 1'b0; user_rd_i = 1'b0; user_addr_i = 1'b1; user_dat_i = '0;
        repeat (4) tick();
        check("reset_dat_o", user_dat_o, 32'h0);
        check("reset_done", {31'd0, capture_done_o}, 32'h0);
        rst_i = 1'b0;
        read_status(v);
        check("reset_status", v, 32'h0);

        // Full 396-bit chain
        ctrl_write(32'h1);
        read_status(v);
        check("armed_status", v, 32'h0000_0001);
        shift_bits(12'h100, 12'h800, 396);
        read_status(v);
        check("capturing_status", v, 32'h018C_0002);
        pulse_latch();
        read_status(v);
        check("full_status", v, 32'h018C_0004);
        check("full_done", {31'd0, capture_done_o}, 32'h1);
        read_word(1'b0, 6'd5, v);
        check("full_r0_w5", v, 32'h0000_5105);
        read_word(1'b1, 6'd32, v);
        check("full_r1_w32", v, 32'h0006_0820);
        read_word(1'b0, 6'd0, v);
        check("full_r0_w0", v, 32'h0000_0100);
        read_word(1'b1, 6'd0, v);
        check("full_r1_w0", v, 32'h0004_0800);

        // Short chain: 390 bits, word 32 keeps the previous capture
        ctrl_write(32'h1);
        shift_bits(12'h200, 12'h900, 390);
        pulse_latch();
        read_status(v);
        check("short_status", v, 32'h0186_000C);
        read_word(1'b0, 6'd31, v);
        check("short_r0_w31", v, 32'h0001_F21F);
        read_word(1'b0, 6'd32, v);
        check("short_r0_w32_kept", v, 32'h0002_0120);
        read_word(1'b1, 6'd32, v);
        check("short_r1_w32_kept", v, 32'h0006_0820);

        // Long chain: 400 bits, extra bits discarded
        ctrl_write(32'h1);
        shift_bits(12'h300, 12'hA00, 400);
        pulse_latch();
        read_status(v);
        check("long_status", v, 32'h0190_001C);
        read_word(1'b0, 6'd32, v);
        check("long_r0_w32", v, 32'h0002_0320);
        read_word(1'b1, 6'd32, v);
        check("long_r1_w32", v, 32'h0006_0A20);

        // Abort mid-capture, then a latch is ignored
        ctrl_write(32'h1);
        shift_bits(12'h000, 12'h000, 30);
        ctrl_write(32'h2);
        pulse_latch();
        read_status(v);
        check("abort_state_bits", v & 32'h7, 32'h0);
        check("abort_done", {31'd0, capture_done_o}, 32'h0);

        // Reset mid-capture
        ctrl_write(32'h1);
        shift_bits(12'h000, 12'h000, 50);
        user_addr_i = 1'b1;
        rst_i = 1'b1;
        tick(); tick();
        check("midrst_dat_o", user_dat_o, 32'h0);
        rst_i = 1'b0;
        read_status(v);
        check("midrst_status", v, 32'h0);
        check("midrst_done", {31'd0, capture_done_o}, 32'h0);

        // Arm then latch with no DAC clocks; also checks latch-to-done latency
        ctrl_write(32'h1);
        tick();
        dac_latch_i = 2'b11;
        tick();
        dac_latch_i = 2'b00;
        tick();
        check("latch_done_early", {31'd0, capture_done_o}, 32'h0);
        tick();
        check("latch_done_on_time", {31'd0, capture_done_o}, 32'h1);
        read_status(v);
        check("nolk_status", v, 32'h0000_000C);

        // Out-of-range pointer, then arm+abort together
        read_word(1'b1, 6'd40, v);
        check("ptr_out_of_range", v, 32'h0006_8000);
        ctrl_write(32'h3);
        read_status(v);
        check("arm_abort_state", v & 32'h7, 32'h0);
        check("arm_abort_done", {31'd0, capture_done_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
